// File: rtl/full_adder_pkg.sv
// Shared constants for the registered ripple-carry adder.
package full_adder_pkg;

    // Classic single-bit full adder unless an instance asks for more.
    parameter int unsigned DefaultWidth = 1;

endpackage

// File: rtl/full_adder_bit.sv
// One combinational full-adder slice; chained by full_adder to form a ripple-carry adder.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    always_comb begin
        p    = a ^ b;
        s    = p ^ cin;
        cout = (a & b) | (cin & p);
    end

endmodule

// File: rtl/full_adder.sv
// Registered ripple-carry adder: {r_out, c} = a + b + r_in, one cycle after in_valid.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             r_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] c,
    output logic             r_out
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;

    logic [WIDTH-1:0] c_q;
    logic             r_out_q;
    logic             out_valid_q;

    assign carry[0] = r_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        full_adder_bit u_bit (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .s    (sum[i]),
            .cout (carry[i+1])
        );
    end

    // Operands are only sampled under in_valid, so X on idle inputs never reaches the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_q         <= '0;
            r_out_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                c_q     <= sum;
                r_out_q <= carry[WIDTH];
            end
        end
    end

    assign c         = c_q;
    assign r_out     = r_out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_full_adder.sv
// Directed and random checks of full_adder at WIDTH = 1 and WIDTH = 8.
module tb_full_adder;

    logic clk;
    logic rst;

    logic       in_valid1, a1, b1, r_in1;
    logic       out_valid1, c1, r_out1;

    logic       in_valid8, r_in8;
    logic [7:0] a8, b8;
    logic       out_valid8, r_out8;
    logic [7:0] c8;

    int errors = 0;
    int checks = 0;

    full_adder #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .a         (a1),
        .b         (b1),
        .r_in      (r_in1),
        .out_valid (out_valid1),
        .c         (c1),
        .r_out     (r_out1)
    );

    full_adder #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid8),
        .a         (a8),
        .b         (b8),
        .r_in      (r_in8),
        .out_valid (out_valid8),
        .c         (c8),
        .r_out     (r_out8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic r);
        in_valid8 = 1'b1;
        a8        = a;
        b8        = b;
        r_in8     = r;
    endtask

    initial begin
        logic [7:0] tt_c;
        logic [7:0] tt_r;
        logic [8:0] exp9;
        logic [2:0] v;

        // Hand-derived truth table, bit i is the result for {a, b, r_in} = i.
        tt_c = 8'b1001_0110;
        tt_r = 8'b1110_1000;

        rst       = 1'b1;
        in_valid1 = 1'b0;
        a1        = 1'bx;
        b1        = 1'bx;
        r_in1     = 1'bx;
        in_valid8 = 1'b0;
        a8        = 'x;
        b8        = 'x;
        r_in8     = 1'bx;
        tick();
        tick();
        check("rst_c1", 32'(c1), 32'd0);
        check("rst_r1", 32'(r_out1), 32'd0);
        check("rst_v1", 32'(out_valid1), 32'd0);
        check("rst_c8", 32'(c8), 32'd0);
        check("rst_v8", 32'(out_valid8), 32'd0);
        rst = 1'b0;

        // Exhaustive WIDTH = 1, back to back.
        for (int i = 0; i < 8; i++) begin
            v         = 3'(i);
            in_valid1 = 1'b1;
            {a1, b1, r_in1} = v;
            tick();
            check($sformatf("tt%0d_c", i), 32'(c1), 32'(tt_c[i]));
            check($sformatf("tt%0d_r", i), 32'(r_out1), 32'(tt_r[i]));
            check($sformatf("tt%0d_v", i), 32'(out_valid1), 32'd1);
        end

        // Reset wins over a concurrent in_valid and that operand is dropped.
        {a1, b1, r_in1} = 3'b111;
        tick();
        {a1, b1, r_in1} = 3'b011;
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        in_valid1 = 1'b0;
        check("rstmid_c", 32'(c1), 32'd0);
        check("rstmid_r", 32'(r_out1), 32'd0);
        check("rstmid_v", 32'(out_valid1), 32'd0);
        tick();
        check("rstmid_novalid", 32'(out_valid1), 32'd0);
        check("rstmid_nores", 32'({r_out1, c1}), 32'd0);

        // Hold with X on idle inputs.
        in_valid1 = 1'b1;
        {a1, b1, r_in1} = 3'b111;
        tick();
        check("load_c", 32'(c1), 32'd1);
        check("load_r", 32'(r_out1), 32'd1);
        in_valid1 = 1'b0;
        {a1, b1, r_in1} = 3'bxxx;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("hold%0d_v", i), 32'(out_valid1), 32'd0);
            check($sformatf("hold%0d_c", i), 32'(c1), 32'd1);
            check($sformatf("hold%0d_r", i), 32'(r_out1), 32'd1);
        end

        // WIDTH = 8 directed wrap cases.
        drive8(8'hFF, 8'h01, 1'b0);
        tick();
        check("w8_ff01_c", 32'(c8), 32'h00);
        check("w8_ff01_r", 32'(r_out8), 32'd1);
        check("w8_ff01_v", 32'(out_valid8), 32'd1);
        drive8(8'hFF, 8'hFF, 1'b1);
        tick();
        check("w8_ffff_c", 32'(c8), 32'hFF);
        check("w8_ffff_r", 32'(r_out8), 32'd1);
        drive8(8'h12, 8'h34, 1'b1);
        tick();
        check("w8_1234_c", 32'(c8), 32'h47);
        check("w8_1234_r", 32'(r_out8), 32'd0);
        drive8(8'hFF, 8'h00, 1'b1);
        tick();
        check("w8_ones_c", 32'(c8), 32'h00);
        check("w8_ones_r", 32'(r_out8), 32'd1);

        // WIDTH = 8 random, back to back against the reference sum.
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] ra, rb;
            logic       rr;
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rr   = 1'($urandom);
            exp9 = {1'b0, ra} + {1'b0, rb} + {8'd0, rr};
            drive8(ra, rb, rr);
            tick();
            check($sformatf("rnd%0d_sum", i), 32'({r_out8, c8}), 32'(exp9));
            check($sformatf("rnd%0d_v", i), 32'(out_valid8), 32'd1);
        end

        in_valid8 = 1'b0;
        tick();
        check("w8_idle_v", 32'(out_valid8), 32'd0);
        check("w8_idle_hold", 32'({r_out8, c8}), 32'(exp9));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
- Registered ripple-carry adder: computes a + b + r_in and presents sum and carry-out one clock later.
- With WIDTH = 1 it is the classic 1-bit full adder (sum "somma", carry "riporto") used as the arithmetic primitive in datapath exercises.
- Wider instances chain one-bit slices, so the same block serves as a small ALU adder stage.

Parameters:
- WIDTH, 1, operand and sum width in bits (>= 1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operands a, b, r_in are valid this cycle.
- a  input  WIDTH  first operand.
- b  input  WIDTH  second operand.
- r_in  input  1  carry-in.
- out_valid  output  1  c and r_out hold a fresh result.
- c  output  WIDTH  sum (somma), registered.
- r_out  output  1  carry-out (riporto), registered.

Behaviour:
- All state updates occur on the rising edge of clk only; no combinational input-to-output path.
- Reset: if rst = 1 at a rising edge, then c = 0, r_out = 0, out_valid = 0. Reset has priority over in_valid.
- Compute: if rst = 0 and in_valid = 1 at an edge, then {r_out, c} <= a + b + r_in, evaluated at WIDTH+1 bits with no truncation of the carry, and out_valid <= 1.
- Idle: if rst = 0 and in_valid = 0, then out_valid <= 0 and c / r_out hold their last values.
- Latency: exactly 1 cycle. Throughput: one operation per cycle; back-to-back in_valid produces back-to-back out_valid.
- No backpressure; results are not stalled. Consumers must sample while out_valid = 1.
- WIDTH = 1 truth table (a b r_in -> c r_out):
  - 000 -> 0 0
  - 001 -> 1 0
  - 010 -> 1 0
  - 011 -> 0 1
  - 100 -> 1 0
  - 101 -> 0 1
  - 110 -> 0 1
  - 111 -> 1 1
- Wrap-around: sum modulo 2^WIDTH appears on c, and overflow appears on r_out.
  - Example: all-ones + 0 + 1 gives c = 0 and r_out = 1.
- Reset mid-operation: an in_valid accepted in the same cycle as rst = 1 is discarded, and no out_valid follows.
- X on inputs while in_valid = 0 must not affect outputs.

Decomposition:
- Package full_adder_pkg: the default width constant only. No typedefs are required.
- One sub-module, full_adder_bit: a combinational 1-bit slice with inputs a, b, cin and outputs s, cout.
  - s = a ^ b ^ cin.
  - cout = (a & b) | (cin & (a ^ b)).
  - Instantiate WIDTH slices in a ripple chain; cin of slice 0 is r_in, and cout of the top slice is the next value of r_out.
- The top level holds only the output registers and the valid flop.

Test Plan:
- WIDTH = 1 exhaustive: drive {a, b, r_in} = 0..7 with in_valid = 1 on consecutive cycles. One cycle later each result must match the truth table above (e.g. 011 -> c = 0, r_out = 1; 111 -> c = 1, r_out = 1), and out_valid must stay high throughout.
- Reset: load 111, then assert rst for one cycle with in_valid = 1. Next cycle c = 0, r_out = 0, out_valid = 0, and the operand presented during reset produces no result.
- Hold: after the result 1/1, drop in_valid for 3 cycles. out_valid = 0, and c = 1, r_out = 1 remain unchanged.
- WIDTH = 8 wrap: a = 0xFF, b = 0x01, r_in = 0 -> c = 0x00, r_out = 1.
  - a = 0xFF, b = 0xFF, r_in = 1 -> c = 0xFF, r_out = 1.
  - a = 0x12, b = 0x34, r_in = 1 -> c = 0x47, r_out = 0.
- WIDTH = 8 random: 1000 back-to-back vectors compared against the reference model {r_out, c} = a + b + r_in delayed by one cycle, with no bubbles in out_valid.
